// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port unified memory.
// One access per two cycles; data wins ties until the fetch port has waited MAX_WAIT grants.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        gnt_i, gnt_d;
    logic        win_d_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        i_rv_q, d_rv_q;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (d_req && (!i_req || starve_q < MAX_W)) begin
                        gnt_d = 1'b1;
                        if (i_req && starve_q < MAX_W)
                            starve_d = starve_q + 4'd1;
                    end else if (i_req) begin
                        gnt_i    = 1'b1;
                        starve_d = 4'd0;
                    end
                    if (gnt_i || gnt_d)
                        state_d = ACCESS;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            win_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_rv_q    <= 1'b0;
            d_rv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (gnt_i || gnt_d) begin
                win_d_q <= gnt_d;
                we_q    <= gnt_d & d_we;
                addr_q  <= gnt_d ? d_addr : i_addr;
                // Write data only matters for stores; fetches leave it untouched.
                if (gnt_d)
                    wdata_q <= d_wdata;
            end
            i_rv_q <= (state_q == ACCESS) && !win_d_q;
            d_rv_q <= (state_q == ACCESS) && win_d_q;
            if (state_q == ACCESS) begin
                if (!win_d_q)
                    i_rdata_q <= mem_rdata;
                else if (!we_q)
                    d_rdata_q <= mem_rdata;
            end
        end
    end

    assign i_gnt     = gnt_i;
    assign d_gnt     = gnt_d;
    assign i_rvalid  = i_rv_q & ~reset;
    assign d_rvalid  = d_rv_q & ~reset;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_we    = (state_q == ACCESS) & win_d_q & we_q & ~reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset-abort,
// idle-bus and post-reset starvation sequences against a small memory model.
module tb_mem_arbiter;
    localparam logic [31:0] IR = 32'h00500113;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] FILL = 32'h11111111;

    logic        clk = 1'b0;
    logic        reset, preload;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63];

    int vectors = 0;
    int errors  = 0;

    mem_arbiter #(.MAX_WAIT(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 64; k++) mem[k] <= FILL;
            mem[2] <= IR;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        ir, dr, dwe;
        logic [31:0] dwd;
        logic        ig, dg, mwe, irv, drv;
        logic [31:0] maddr, ird, drd;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t v(logic ir, logic dr, logic dwe, logic [31:0] dwd,
                               logic ig, logic dg, logic mwe, logic irv, logic drv,
                               logic [31:0] maddr, logic [31:0] ird, logic [31:0] drd);
        vec_t r;
        r.ir = ir; r.dr = dr; r.dwe = dwe; r.dwd = dwd;
        r.ig = ig; r.dg = dg; r.mwe = mwe; r.irv = irv; r.drv = drv;
        r.maddr = maddr; r.ird = ird; r.drd = drd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] obs();
        return {27'd0, i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid, mem_addr, i_rdata, d_rdata};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        string seq;
        int    gcount;

        // fetch from 0x8, store/load 0x40, then both ports held for starvation order D,D,I,D,D,I
        tbl[0]  = v(1,0,0,0,   1,0,0,0,0, 32'h0,  0,  0);
        tbl[1]  = v(0,0,0,0,   0,0,0,0,0, 32'h8,  0,  0);
        tbl[2]  = v(0,0,0,0,   0,0,0,1,0, 32'h8,  IR, 0);
        tbl[3]  = v(0,1,1,DB,  0,1,0,0,0, 32'h8,  IR, 0);
        tbl[4]  = v(0,0,0,0,   0,0,1,0,0, 32'h40, IR, 0);
        tbl[5]  = v(0,1,0,0,   0,1,0,0,1, 32'h40, IR, 0);
        tbl[6]  = v(0,0,0,0,   0,0,0,0,0, 32'h40, IR, 0);
        tbl[7]  = v(0,0,0,0,   0,0,0,0,1, 32'h40, IR, DB);
        tbl[8]  = v(1,1,0,0,   0,1,0,0,0, 32'h40, IR, DB);
        tbl[9]  = v(1,1,0,0,   0,0,0,0,0, 32'h40, IR, DB);
        tbl[10] = v(1,1,0,0,   0,1,0,0,1, 32'h40, IR, DB);
        tbl[11] = v(1,1,0,0,   0,0,0,0,0, 32'h40, IR, DB);
        tbl[12] = v(1,1,0,0,   1,0,0,0,1, 32'h40, IR, DB);
        tbl[13] = v(1,1,0,0,   0,0,0,0,0, 32'h8,  IR, DB);
        tbl[14] = v(1,1,0,0,   0,1,0,1,0, 32'h8,  IR, DB);
        tbl[15] = v(1,1,0,0,   0,0,0,0,0, 32'h40, IR, DB);
        tbl[16] = v(1,1,0,0,   0,1,0,0,1, 32'h40, IR, DB);
        tbl[17] = v(1,1,0,0,   0,0,0,0,0, 32'h40, IR, DB);
        tbl[18] = v(1,1,0,0,   1,0,0,0,1, 32'h40, IR, DB);
        tbl[19] = v(0,0,0,0,   0,0,0,0,0, 32'h8,  IR, DB);
        tbl[20] = v(0,0,0,0,   0,0,0,1,0, 32'h8,  IR, DB);

        reset = 1'b1; preload = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h8; d_addr = 32'h40; d_wdata = 32'h0;
        repeat (3) cyc();
        preload = 1'b0;
        #1;
        chk("reset_state", {5'b0, i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid, mem_addr, mem_wdata, i_rdata, d_rdata}, 128'd0);

        foreach (tbl[n]) begin
            cyc();
            reset = 1'b0;
            i_req = tbl[n].ir; d_req = tbl[n].dr; d_we = tbl[n].dwe; d_wdata = tbl[n].dwd;
            #1;
            chk($sformatf("row%0d", n), obs(),
                {27'd0, tbl[n].ig, tbl[n].dg, tbl[n].mwe, tbl[n].irv, tbl[n].drv,
                 tbl[n].maddr, tbl[n].ird, tbl[n].drd});
        end

        // idle bus: nothing moves, read-data registers hold
        for (int k = 0; k < 10; k++) begin
            cyc();
            i_req = 1'b0; d_req = 1'b0;
            #1;
            chk($sformatf("idle%0d", k), {i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid, i_rdata, d_rdata},
                {5'b0, IR, DB});
        end

        // store aborted by reset during its access cycle
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        #1;
        chk("abort_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
        cyc();
        d_req = 1'b0; d_we = 1'b0; reset = 1'b1;
        #1;
        chk("abort_we_in_rst", {29'd0, mem_we, i_gnt, d_gnt}, 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("abort_after", {d_rvalid, i_rvalid, mem_we, mem_addr, i_rdata, d_rdata}, 99'd0);
        cyc();
        i_req = 1'b1; i_addr = 32'h8;
        #1;
        chk("abort_idle_gnt", {d_rvalid, mem_we, i_gnt}, 3'b001);
        cyc();
        i_req = 1'b0;
        #1;
        chk("abort_mem_word", mem[32], FILL);
        cyc();
        #1;
        chk("abort_fetch", {i_rvalid, i_rdata}, {1'b1, IR});

        // both requesting straight out of reset: D first, I after MAX_WAIT data grants
        cyc();
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_addr = 32'h40;
        #1;
        chk("rst_gnt_mask", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_we}, 5'b0);
        cyc();
        seq = "";
        gcount = 0;
        for (int c = 0; c < 20 && gcount < 6; c++) begin
            cyc();
            reset = 1'b0;
            #1;
            if (c == 0) chk("first_gnt", {i_gnt, d_gnt}, 2'b01);
            if (i_gnt && d_gnt) begin
                vectors++; errors++;
                $display("FAIL dual_gnt: both grants high at cycle %0d", c);
            end
            if (d_gnt) begin seq = {seq, "D"}; gcount++; end
            else if (i_gnt) begin seq = {seq, "I"}; gcount++; end
        end
        vectors++;
        if (seq != "DDIDDI") begin
            errors++;
            $display("FAIL grant_order: got %s expected DDIDDI", seq);
        end
        i_req = 1'b0; d_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
